// File: rtl/test_probe_pkg.sv
// test_probe shared definitions: register map and CTRL bit positions.
// Imported by test_probe and probe_stretch.
package test_probe_pkg;

    localparam logic [2:0] REG_SELECT  = 3'd0;
    localparam logic [2:0] REG_STRETCH = 3'd1;
    localparam logic [2:0] REG_EDGES   = 3'd2;
    localparam logic [2:0] REG_PATTERN = 3'd3;
    localparam logic [2:0] REG_MASK    = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;

    localparam int CTRL_ARM  = 0;
    localparam int CTRL_TRIG = 1;

endpackage

// File: rtl/probe_stretch.sv
// probe_stretch: one-bit rising-edge detector plus retriggerable
// down-counter that keeps a short pulse visible for STRETCH cycles.
module probe_stretch
    import test_probe_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          bit_in,
    input  logic          clr,
    input  logic [SW-1:0] stretch,
    output logic          rise,
    output logic          hold
);

    logic          prev_q, prev_d;
    logic [SW-1:0] cnt_q, cnt_d;

    assign rise = bit_in & ~prev_q;
    assign hold = (cnt_q != '0);

    // next count: clear beats reload, reload beats decrement
    always_comb begin
        prev_d = bit_in;
        cnt_d  = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (rise)
            cnt_d = stretch;
        else if (hold)
            cnt_d = cnt_q - SW'(1);
    end

    // edge history and counter state
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/test_probe.sv
// test_probe: selectable, stretched probe output to the header pins.
// Define TEST_PROBE_TRIGGER_EN to build the pattern-match freeze.
module test_probe
    import test_probe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHANS = 4,
    parameter int SW    = 8,
    parameter int CW    = 16
) (
    input  logic                   ck,
    input  logic                   rst_n,
    input  logic [CHANS*WIDTH-1:0] probe_in,
    input  logic                   bus_valid,
    input  logic                   bus_write,
    input  logic [2:0]             bus_addr,
    input  logic [31:0]            bus_wdata,
    output logic [31:0]            bus_rdata,
    output logic                   bus_ready,
    output logic [WIDTH-1:0]       test_out
);

    logic [3:0]       select_q, select_d;
    logic [SW-1:0]    stretch_q, stretch_d;
    logic [CW-1:0]    edges_q, edges_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      rd_val;
    logic [WIDTH-1:0] rise, hold;
    logic             fire, wr, sel_wr, edge_wr, freeze;
    logic             unused;

    assign fire    = bus_valid & ~ready_q;
    assign wr      = fire & bus_write;
    assign sel_wr  = wr && (bus_addr == REG_SELECT);
    assign edge_wr = wr && (bus_addr == REG_EDGES);
    assign unused  = ^{bus_wdata, rise};

    assign bus_ready = ready_q;
    assign bus_rdata = rdata_q;
    assign test_out  = out_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_str
            probe_stretch #(.SW(SW)) u_str (
                .ck      (ck),
                .rst_n   (rst_n),
                .bit_in  (sel_q[gi]),
                .clr     (sel_wr),
                .stretch (stretch_q),
                .rise    (rise[gi]),
                .hold    (hold[gi])
            );
        end
    endgenerate

`ifdef TEST_PROBE_TRIGGER_EN
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             armed_q, armed_d;
    logic             trig_q, trig_d;
    logic             freeze_q, freeze_d;
    logic             arm_wr, match;

    assign arm_wr = wr && (bus_addr == REG_CTRL) && bus_wdata[CTRL_ARM];
    assign match  = (((sel_q ^ pattern_q) & mask_q) == '0);
    assign freeze = freeze_q;

    // arm / fire / release of the output freeze
    always_comb begin
        pattern_d = pattern_q;
        mask_d    = mask_q;
        armed_d   = armed_q;
        trig_d    = trig_q;
        freeze_d  = freeze_q;
        if (wr && (bus_addr == REG_PATTERN))
            pattern_d = bus_wdata[WIDTH-1:0];
        if (wr && (bus_addr == REG_MASK))
            mask_d = bus_wdata[WIDTH-1:0];
        if (arm_wr) begin
            armed_d  = 1'b1;
            trig_d   = 1'b0;
            freeze_d = 1'b0;
        end else if (armed_q && match) begin
            armed_d  = 1'b0;
            trig_d   = 1'b1;
            freeze_d = 1'b1;
        end
        if (sel_wr)
            freeze_d = 1'b0;
    end

    // trigger state
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            mask_q    <= '0;
            armed_q   <= 1'b0;
            trig_q    <= 1'b0;
            freeze_q  <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            armed_q   <= armed_d;
            trig_q    <= trig_d;
            freeze_q  <= freeze_d;
        end
    end
`else
    assign freeze = 1'b0;
`endif

    // register read mux
    always_comb begin
        rd_val = '0;
        case (bus_addr)
            REG_SELECT:  rd_val[3:0]    = select_q;
            REG_STRETCH: rd_val[SW-1:0] = stretch_q;
            REG_EDGES:   rd_val[CW-1:0] = edges_q;
`ifdef TEST_PROBE_TRIGGER_EN
            REG_PATTERN: rd_val[WIDTH-1:0] = pattern_q;
            REG_MASK:    rd_val[WIDTH-1:0] = mask_q;
            REG_CTRL: begin
                rd_val[CTRL_ARM]  = armed_q;
                rd_val[CTRL_TRIG] = trig_q;
            end
`else
            REG_PATTERN, REG_MASK, REG_CTRL: rd_val = '0;
`endif
            default:     rd_val = '0;
        endcase
    end

    // group select, bus registers, edge counter and output
    always_comb begin
        sel_d = '0;
        for (int k = 0; k < CHANS; k++)
            if (select_q == 4'(k))
                sel_d = probe_in[k*WIDTH +: WIDTH];
        select_d  = sel_wr ? bus_wdata[3:0] : select_q;
        stretch_d = (wr && (bus_addr == REG_STRETCH))
                  ? bus_wdata[SW-1:0] : stretch_q;
        edges_d = edges_q;
        if (sel_wr || edge_wr)
            edges_d = '0;
        else if (rise[0] && (edges_q != '1))
            edges_d = edges_q + CW'(1);
        ready_d = fire;
        rdata_d = (fire && !bus_write) ? rd_val : 32'd0;
        out_d   = freeze ? out_q : (sel_q | hold);
    end

    // core state
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            select_q  <= '0;
            stretch_q <= '0;
            edges_q   <= '0;
            sel_q     <= '0;
            out_q     <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            select_q  <= select_d;
            stretch_q <= stretch_d;
            edges_q   <= edges_d;
            sel_q     <= sel_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_test_probe.sv
// tb_test_probe: directed and randomized checks of test_probe against
// a window-based model of the select / stretch / edge-count rules.
module tb_test_probe;
    import test_probe_pkg::*;

    localparam int WIDTH = 8;
    localparam int CHANS = 4;
    localparam int SW    = 8;
    localparam int CW    = 10;
    localparam int EMAX  = (1 << CW) - 1;

    logic                   ck = 1'b0;
    logic                   rst_n = 1'b0;
    logic [CHANS*WIDTH-1:0] probe_in = '0;
    logic                   bus_valid = 1'b0;
    logic                   bus_write = 1'b0;
    logic [2:0]             bus_addr = '0;
    logic [31:0]            bus_wdata = '0;
    logic [31:0]            bus_rdata;
    logic                   bus_ready;
    logic [WIDTH-1:0]       test_out;

    int n_run  = 0;
    int n_fail = 0;

    always #5 ck = ~ck;

    test_probe #(
        .WIDTH(WIDTH), .CHANS(CHANS), .SW(SW), .CW(CW)
    ) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .probe_in  (probe_in),
        .bus_valid (bus_valid),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .test_out  (test_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic bus(input logic w, input logic [2:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        logic ok;
        ok = 1'b0;
        @(posedge ck); #1;
        bus_valid = 1'b1; bus_write = w; bus_addr = a; bus_wdata = d;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge ck); #1;
            ok = bus_ready;
        end
        check("bus_ack", 32'(ok), 32'd1);
        rd = bus_rdata;
        @(posedge ck); #1;
        bus_valid = 1'b0; bus_write = 1'b0;
        check("ready_drop", 32'(bus_ready), 32'd0);
        @(posedge ck); #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] x;
        bus(1'b1, a, d, x);
    endtask

    task automatic rdc(input string tag, input logic [2:0] a,
                       input logic [31:0] exp);
        logic [31:0] x;
        bus(1'b0, a, 32'd0, x);
        check(tag, x, exp);
    endtask

    function automatic logic [WIDTH-1:0] grp(input int s,
                                             input logic [CHANS*WIDTH-1:0] v);
        if (s < CHANS) return v[s*WIDTH +: WIDTH];
        return '0;
    endfunction

    // out in cycle m = sel(m-1) | any rise in the last STRETCH cycles
    task automatic rand_phase(input int s, input int st, input int n);
        logic [WIDTH-1:0]       h[$];
        logic [WIDTH-1:0]       exp;
        logic [CHANS*WIDTH-1:0] v;
        int                     rises;
        rises = 0;
        probe_in = '0;
        wr(REG_SELECT, 32'(s));
        wr(REG_STRETCH, 32'(st));
        cyc(2);
        h.push_back('0);
        v = '0;
        for (int m = 1; m <= n; m++) begin
            @(posedge ck);
            h.push_back(grp(s, v));
            #1;
            exp = h[m-1];
            for (int k = m - 1 - st; k <= m - 2; k++)
                if (k >= 1) exp |= h[k] & ~h[k-1];
            check("rand_out", test_out, exp);
            if (h[m][0] && !h[m-1][0]) rises++;
            v = (m == n) ? '0 : ($urandom & $urandom);
            probe_in = v;
        end
        cyc(2);
        rdc("rand_edges", REG_EDGES, 32'((rises > EMAX) ? EMAX : rises));
    endtask

    initial begin
        logic [31:0] x;
        int          cnt;

        // reset state
        cyc(3);
        check("rst_out", test_out, 0);
        check("rst_ready", 32'(bus_ready), 0);
        check("rst_rdata", bus_rdata, 0);
        rst_n = 1'b1;
        cyc(2);
        rdc("rst_select", REG_SELECT, 0);
        rdc("rst_stretch", REG_STRETCH, 0);
        rdc("rst_edges", REG_EDGES, 0);

        // group 2 pass-through, two-cycle latency
        wr(REG_SELECT, 2);
        wr(REG_STRETCH, 0);
        x = $urandom;
        x[23:16] = 8'hA5;
        probe_in = x;
        cyc(1);
        check("sel2_lat1", test_out, 0);
        cyc(1);
        check("sel2_lat2", test_out, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            x[23:16] = 8'hA5;
            probe_in = x;
            cyc(1);
            check("sel2_other", test_out, 8'hA5);
        end
        probe_in = '0;

        // stretch: single pulse, then retriggered pulse
        wr(REG_SELECT, 0);
        wr(REG_STRETCH, 5);
        for (int dbl = 0; dbl < 2; dbl++) begin
            cnt = 0;
            for (int i = 0; i < 24; i++) begin
                probe_in = (i == 0 || (dbl == 1 && i == 3)) ? 32'h8 : 32'h0;
                cyc(1);
                cnt += int'(test_out[3]);
            end
            check(dbl ? "stretch_retrig" : "stretch_single",
                  32'(cnt), dbl ? 32'd9 : 32'd6);
        end

        // out-of-range select
        wr(REG_SELECT, 7);
        for (int i = 0; i < 4; i++) begin
            probe_in = $urandom;
            cyc(1);
            check("sel7_out", test_out, 0);
        end
        probe_in = '0;
        rdc("sel7_readback", REG_SELECT, 7);

        // edge counter saturation and clears
        wr(REG_SELECT, 0);
        wr(REG_STRETCH, 0);
        for (int i = 0; i < 2 * (EMAX + 80); i++) begin
            probe_in = (i % 2 == 0) ? 32'h1 : 32'h0;
            cyc(1);
        end
        probe_in = '0;
        cyc(2);
        rdc("edges_sat", REG_EDGES, EMAX);
        wr(REG_EDGES, 0);
        rdc("edges_wclr", REG_EDGES, 0);
        for (int i = 0; i < 10; i++) begin
            probe_in = (i % 2 == 0) ? 32'h1 : 32'h0;
            cyc(1);
        end
        probe_in = '0;
        cyc(2);
        rdc("edges_five", REG_EDGES, 5);
        wr(REG_SELECT, 0);
        rdc("edges_selclr", REG_EDGES, 0);

        // randomized phases against the window model
        for (int r = 0; r < 6; r++)
            rand_phase($urandom_range(0, 5), $urandom_range(0, 6), 60);

`ifdef TEST_PROBE_TRIGGER_EN
        // pattern trigger freezes the output
        wr(REG_SELECT, 0);
        wr(REG_STRETCH, 0);
        wr(REG_PATTERN, 32'h3C);
        wr(REG_MASK, 32'hFF);
        rdc("pattern_rb", REG_PATTERN, 32'h3C);
        wr(REG_CTRL, 32'h1);
        probe_in = 32'h3C;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            probe_in = $urandom;
            cyc(1);
            if (i > 0) check("trig_frozen", test_out, 8'h3C);
        end
        bus(1'b0, REG_CTRL, 0, x);
        check("trig_status", 32'(x[CTRL_TRIG]), 1);
        probe_in = 32'h11;
        wr(REG_CTRL, 32'h1);
        cyc(2);
        check("rearm_release", test_out, 8'h11);
        bus(1'b0, REG_CTRL, 0, x);
        check("rearm_status", 32'(x[CTRL_TRIG]), 0);
        wr(REG_MASK, 0);
        wr(REG_CTRL, 32'h1);
        probe_in = 32'h22;
        cyc(3);
        check("mask0_frozen", test_out, 8'h11);
        bus(1'b0, REG_CTRL, 0, x);
        check("mask0_status", 32'(x[CTRL_TRIG]), 1);
        wr(REG_SELECT, 0);
        cyc(2);
        check("selwr_release", test_out, 8'h22);
        probe_in = '0;
`else
        // trigger registers absent: read 0, no freeze
        wr(REG_PATTERN, 32'h3C);
        wr(REG_MASK, 32'hFF);
        wr(REG_CTRL, 32'h1);
        rdc("nopat_rb", REG_PATTERN, 0);
        rdc("nomask_rb", REG_MASK, 0);
        rdc("noctrl_rb", REG_CTRL, 0);
        wr(REG_SELECT, 0);
        wr(REG_STRETCH, 0);
        probe_in = 32'h3C;
        cyc(1);
        probe_in = 32'h5A;
        cyc(2);
        check("nofreeze", test_out, 8'h5A);
        probe_in = '0;
`endif

        // reset mid-stretch and mid-access
        wr(REG_SELECT, 0);
        wr(REG_STRETCH, 200);
        probe_in = 32'hFF;
        cyc(1);
        probe_in = '0;
        cyc(3);
        check("pre_rst_out", test_out, 8'hFF);
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = REG_STRETCH;
        cyc(1);
        check("pre_rst_ready", 32'(bus_ready), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", test_out, 0);
        check("arst_ready", 32'(bus_ready), 0);
        check("arst_rdata", bus_rdata, 0);
        bus_valid = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        rdc("post_rst_stretch", REG_STRETCH, 0);
        rdc("post_rst_edges", REG_EDGES, 0);
        check("post_rst_out", test_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
